// File: rtl/lcd_char_writer.sv
// lcd_char_writer
//   Drives a 16x2 HD44780-compatible character LCD over its 8-bit parallel bus.
//   After reset it waits for the panel to power up and sends the init command
//   sequence once. It then refreshes both display lines continuously from a
//   per-frame snapshot of the text inputs.
//
//   All bus activity is paced by a tick strobe that fires once every TICK_DIV
//   clocks. Each byte takes two ticks:
//   - phase A: rs/data are driven and E rises;
//   - phase B: E falls.
//   rs/data then stay put until the next byte's phase A, so they are stable
//   for a whole tick on either side of the falling edge of E.
//
// Parameters
//   TICK_DIV          clk cycles per LCD step tick (min 2)
//   POWERUP_TICKS     ticks waited after reset before the first command (min 1)
//   CLEAR_WAIT_TICKS  idle ticks after the clear-display command (min 1)
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   line1       row 0 text, [127:120] = column 0 ... [7:0] = column 15
//   line2       row 1 text, same packing
//   lcd_e       LCD enable strobe
//   lcd_rs      register select: 0 = command, 1 = data
//   lcd_rw      read/write select, always 0 (write only)
//   lcd_data    LCD data bus
//   init_done   high once the init sequence has completed, until reset
//   frame_done  one-cycle pulse on the phase B tick of row 1, column 15
module lcd_char_writer #(
  parameter int TICK_DIV         = 50000,
  parameter int POWERUP_TICKS    = 20,
  parameter int CLEAR_WAIT_TICKS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] line1,
  input  logic [127:0] line2,
  output logic         lcd_e,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_data,
  output logic         init_done,
  output logic         frame_done
);

  localparam int TW       = $clog2(TICK_DIV);
  localparam int WAIT_MAX = (POWERUP_TICKS > CLEAR_WAIT_TICKS) ? POWERUP_TICKS
                                                               : CLEAR_WAIT_TICKS;
  localparam int WW       = $clog2(WAIT_MAX + 1);

  localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_DIV - 1);
  localparam logic [WW-1:0] POWERUP_LAST = WW'(POWERUP_TICKS - 1);
  localparam logic [WW-1:0] CLEAR_LAST   = WW'(CLEAR_WAIT_TICKS - 1);

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    CLR_WAIT,
    ADDR1,
    ROW1,
    ADDR2,
    ROW2
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          phase_b;
  logic [1:0]    init_idx;
  logic [3:0]    col;
  logic [WW-1:0] wait_cnt;
  logic [127:0]  snap1;
  logic [127:0]  snap2;

  assign lcd_rw = 1'b0;
  assign tick   = (tick_cnt == TICK_LAST);

  // Function-set 8-bit/2-line, display on, entry-mode increment, clear.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  // Anything the panel cannot render as printable ASCII becomes a space.
  function automatic logic [7:0] printable(input logic [7:0] b);
    printable = (b >= 8'h20 && b <= 8'h7E) ? b : 8'h20;
  endfunction

  // Column c sits at bits [8*(15-c)+7 : 8*(15-c)]; ~c equals 15-c for 4 bits.
  function automatic logic [7:0] col_byte(input logic [127:0] s, input logic [3:0] c);
    logic [127:0] sh;
    sh       = s >> {~c, 3'b000};
    col_byte = sh[7:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PWRUP;
      phase_b    <= 1'b0;
      init_idx   <= 2'd0;
      col        <= 4'd0;
      wait_cnt   <= '0;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
      snap1      <= {16{8'h20}};
      snap2      <= {16{8'h20}};
    end else begin
      frame_done <= 1'b0;
      if (tick) begin
        case (state)
          PWRUP: begin
            if (wait_cnt == POWERUP_LAST) begin
              wait_cnt <= '0;
              state    <= INIT;
            end else begin
              wait_cnt <= wait_cnt + WW'(1);
            end
          end

          CLR_WAIT: begin
            if (wait_cnt == CLEAR_LAST) begin
              wait_cnt  <= '0;
              init_done <= 1'b1;
              state     <= ADDR1;
            end else begin
              wait_cnt <= wait_cnt + WW'(1);
            end
          end

          default: begin
            if (!phase_b) begin
              // Phase A: present the byte and raise E.
              lcd_e   <= 1'b1;
              phase_b <= 1'b1;
              case (state)
                INIT: begin
                  lcd_rs   <= 1'b0;
                  lcd_data <= init_cmd(init_idx);
                end
                ADDR1: begin
                  lcd_rs   <= 1'b0;
                  lcd_data <= 8'h80;
                  // Freeze both rows here so a whole frame shows one coherent text.
                  for (int i = 0; i < 16; i++) begin
                    snap1[8*i +: 8] <= printable(line1[8*i +: 8]);
                    snap2[8*i +: 8] <= printable(line2[8*i +: 8]);
                  end
                end
                ROW1: begin
                  lcd_rs   <= 1'b1;
                  lcd_data <= col_byte(snap1, col);
                end
                ADDR2: begin
                  lcd_rs   <= 1'b0;
                  lcd_data <= 8'hC0;
                end
                ROW2: begin
                  lcd_rs   <= 1'b1;
                  lcd_data <= col_byte(snap2, col);
                end
                default: begin
                end
              endcase
            end else begin
              // Phase B: drop E, hold rs/data, advance to the next byte.
              lcd_e   <= 1'b0;
              phase_b <= 1'b0;
              case (state)
                INIT: begin
                  if (init_idx == 2'd3) begin
                    init_idx <= 2'd0;
                    state    <= CLR_WAIT;
                  end else begin
                    init_idx <= init_idx + 2'd1;
                  end
                end
                ADDR1: begin
                  state <= ROW1;
                end
                ROW1: begin
                  col <= col + 4'd1;
                  if (col == 4'd15) begin
                    state <= ADDR2;
                  end
                end
                ADDR2: begin
                  state <= ROW2;
                end
                ROW2: begin
                  col <= col + 4'd1;
                  if (col == 4'd15) begin
                    frame_done <= 1'b1;
                    state      <= ADDR1;
                  end
                end
                default: begin
                end
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule
